// File: rtl/vga_pkg.sv
// Shared VGA pipeline widths, font geometry and the pixel bundle that
// travels alongside the text-overlay datapath.
package vga_pkg;

    localparam int RGB_W         = 12;
    localparam int COUNT_W       = 11;
    localparam int FONT_W        = 8;
    localparam int FONT_H        = 16;
    localparam int DRAW_CHAR_LAT = 3;

    typedef struct packed {
        logic [COUNT_W-1:0] hcount;
        logic [COUNT_W-1:0] vcount;
        logic               hsync;
        logic               vsync;
        logic               hblnk;
        logic               vblnk;
        logic [RGB_W-1:0]   rgb;
    } vga_bus_t;

endpackage

// File: rtl/delay.sv
// Fixed-length register delay line with synchronous active-high clear.
// CLK_DEL = 0 degenerates to a wire.
module delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 1
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    generate
        if (CLK_DEL == 0) begin : g_wire
            assign o_dout = i_din;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [CLK_DEL];

            always_ff @(posedge pclk) begin
                if (rst) begin
                    for (int i = 0; i < CLK_DEL; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= i_din;
                    for (int i = 1; i < CLK_DEL; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign o_dout = r_pipe[CLK_DEL-1];
        end
    endgenerate

endmodule

// File: rtl/draw_rect_char.sv
// Text overlay: addresses char_rom/font_rom from the pixel position and paints
// font pixels over the RGB stream. Define TEXT_BG_EN for an opaque text box.
module draw_rect_char
    import vga_pkg::*;
#(
    parameter logic [COUNT_W-1:0] XPOS       = 11'd0,
    parameter logic [COUNT_W-1:0] YPOS       = 11'd0,
    parameter int                 COLS       = 16,
    parameter int                 ROWS       = 16,
    parameter logic [RGB_W-1:0]   TEXT_COLOR = 12'hFFF,
    parameter logic [RGB_W-1:0]   BG_COLOR   = 12'h000
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] hcount_in,
    input  logic [COUNT_W-1:0] vcount_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               hblnk_in,
    input  logic               vblnk_in,
    input  logic [RGB_W-1:0]   rgb_in,
    input  logic [FONT_W-1:0]  char_pixels,
    output logic [7:0]         char_xy,
    output logic [3:0]         char_line,
    output logic [COUNT_W-1:0] hcount_out,
    output logic [COUNT_W-1:0] vcount_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               hblnk_out,
    output logic               vblnk_out,
    output logic [RGB_W-1:0]   rgb_out
);

    // One extra bit so XPOS + width cannot wrap at the top of the count range.
    typedef logic [COUNT_W:0] cnt_ext_t;

    localparam cnt_ext_t X_LO = cnt_ext_t'(XPOS);
    localparam cnt_ext_t Y_LO = cnt_ext_t'(YPOS);
    localparam cnt_ext_t X_HI = cnt_ext_t'(XPOS) + cnt_ext_t'(FONT_W * COLS);
    localparam cnt_ext_t Y_HI = cnt_ext_t'(YPOS) + cnt_ext_t'(FONT_H * ROWS);

`ifdef TEXT_BG_EN
    localparam logic BG_EN = 1'b1;
`else
    localparam logic BG_EN = 1'b0;
`endif

    function automatic logic font_bit(input logic [FONT_W-1:0] row, input logic [2:0] px);
        return row[3'(FONT_W-1) - px];
    endfunction

    logic       w_in_rect;
    logic [6:0] w_dx;
    logic [7:0] w_dy;

    assign w_in_rect = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI) &&
                       ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);
    assign w_dx = 7'(hcount_in - XPOS);
    assign w_dy = 8'(vcount_in - YPOS);

    // Timing and colour ride a two-deep delay line to meet char_pixels.
    vga_bus_t w_bus_p0;
    vga_bus_t w_bus_p2;

    assign w_bus_p0 = '{hcount: hcount_in, vcount: vcount_in,
                        hsync: hsync_in, vsync: vsync_in,
                        hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

    delay #(
        .WIDTH   ($bits(vga_bus_t)),
        .CLK_DEL (DRAW_CHAR_LAT - 1)
    ) u_bus_delay (
        .pclk   (pclk),
        .rst    (rst),
        .i_din  (w_bus_p0),
        .o_dout (w_bus_p2)
    );

    // Stage 1: rom address plus the position facts needed later.
    logic       r_in_rect_p1;
    logic [2:0] r_dx_p1;

    always_ff @(posedge pclk) begin
        if (rst) begin
            char_xy      <= '0;
            char_line    <= '0;
            r_in_rect_p1 <= 1'b0;
            r_dx_p1      <= '0;
        end else begin
            char_xy      <= w_in_rect ? {w_dy[7:4], w_dx[6:3]} : 8'h00;
            char_line    <= w_in_rect ? w_dy[3:0] : 4'h0;
            r_in_rect_p1 <= w_in_rect;
            r_dx_p1      <= w_dx[2:0];
        end
    end

    // Stage 2: aligned with the registered font_rom read.
    logic       r_in_rect_p2;
    logic [2:0] r_dx_p2;

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_in_rect_p2 <= 1'b0;
            r_dx_p2      <= '0;
        end else begin
            r_in_rect_p2 <= r_in_rect_p1;
            r_dx_p2      <= r_dx_p1;
        end
    end

    logic [RGB_W-1:0] w_rgb_p2;

    always_comb begin
        w_rgb_p2 = w_bus_p2.rgb;
        if (w_bus_p2.hblnk || w_bus_p2.vblnk) begin
            w_rgb_p2 = '0;
        end else if (r_in_rect_p2 && font_bit(char_pixels, r_dx_p2)) begin
            w_rgb_p2 = TEXT_COLOR;
        end else if (r_in_rect_p2 && BG_EN) begin
            w_rgb_p2 = BG_COLOR;
        end
    end

    // Stage 3: output register.
    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= w_bus_p2.hcount;
            vcount_out <= w_bus_p2.vcount;
            hsync_out  <= w_bus_p2.hsync;
            vsync_out  <= w_bus_p2.vsync;
            hblnk_out  <= w_bus_p2.hblnk;
            vblnk_out  <= w_bus_p2.vblnk;
            rgb_out    <= w_rgb_p2;
        end
    end

endmodule

// File: tb/tb_draw_rect_char.sv
// Bench for draw_rect_char: font_rom stand-in, per-cycle reference model and
// directed literal checks around the rectangle edges.
module tb_draw_rect_char;

    localparam int XP   = 100;
    localparam int YP   = 50;
    localparam int COLS = 16;
    localparam int ROWS = 16;
    localparam logic [11:0] TEXT = 12'hE71;
    localparam logic [11:0] BG   = 12'h123;
    localparam int HN   = 8192;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [7:0]  char_pixels = '0;
    logic [7:0]  char_xy;
    logic [3:0]  char_line;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    logic        font_ovr_en = 1'b0;
    logic [7:0]  font_ovr    = '0;

    int n_vec = 0;
    int n_err = 0;
    int n     = 0;

    typedef struct {
        logic       rst;
        int         h;
        int         v;
        logic       hs, vs, hb, vb;
        int         rgb;
        logic       oen;
        logic [7:0] ov;
    } rec_t;

    rec_t hist [HN];

    draw_rect_char #(
        .XPOS(11'd100), .YPOS(11'd50), .COLS(COLS), .ROWS(ROWS),
        .TEXT_COLOR(TEXT), .BG_COLOR(BG)
    ) dut (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .char_pixels(char_pixels),
        .char_xy(char_xy), .char_line(char_line),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 pclk = ~pclk;

    function automatic logic [7:0] font_fn(input logic [7:0] xy, input logic [3:0] ln);
        return xy ^ {ln, ~ln};
    endfunction

    // font_rom stand-in: registered read of the glyph row
    always @(posedge pclk)
        char_pixels <= font_ovr_en ? font_ovr : font_fn(char_xy, char_line);

    always @(posedge pclk) begin
        hist[n % HN] <= '{rst, int'(hcount_in), int'(vcount_in), hsync_in, vsync_in,
                          hblnk_in, vblnk_in, int'(rgb_in), font_ovr_en, font_ovr};
        n <= n + 1;
    end

    function automatic logic m_in_rect(input int h, input int v);
        return (h >= XP) && (h < XP + 8 * COLS) && (v >= YP) && (v < YP + 16 * ROWS);
    endfunction

    function automatic int m_xy(input int h, input int v);
        if (!m_in_rect(h, v)) return 0;
        return ((v - YP) / 16) * 16 + (h - XP) / 8;
    endfunction

    function automatic int m_line(input int h, input int v);
        if (!m_in_rect(h, v)) return 0;
        return (v - YP) % 16;
    endfunction

    function automatic int m_rgb(input rec_t r, input logic [7:0] font);
        int px;
        if (r.hb || r.vb) return 0;
        if (!m_in_rect(r.h, r.v)) return r.rgb;
        px = (r.h - XP) % 8;
        if (((font >> (7 - px)) & 8'h01) != 0) return int'(TEXT);
`ifdef TEXT_BG_EN
        return int'(BG);
`else
        return r.rgb;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge pclk) begin
        if (n >= 1) begin
            rec_t r;
            r = hist[(n - 1) % HN];
            check("char_xy",   int'(char_xy),   r.rst ? 0 : m_xy(r.h, r.v));
            check("char_line", int'(char_line), r.rst ? 0 : m_line(r.h, r.v));
        end
        if (n >= 3) begin
            rec_t r, r1, r2;
            logic [7:0] font;
            r  = hist[(n - 3) % HN];
            r1 = hist[(n - 2) % HN];
            r2 = hist[(n - 1) % HN];
            if (r.rst || r1.rst || r2.rst) begin
                check("flush_hcount", int'(hcount_out), 0);
                check("flush_vcount", int'(vcount_out), 0);
                check("flush_sync",   int'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 0);
                check("flush_rgb",    int'(rgb_out), 0);
            end else begin
                font = r1.oen ? r1.ov : font_fn(8'(m_xy(r.h, r.v)), 4'(m_line(r.h, r.v)));
                check("hcount_out", int'(hcount_out), r.h);
                check("vcount_out", int'(vcount_out), r.v);
                check("sync_blnk",  int'({hsync_out, vsync_out, hblnk_out, vblnk_out}),
                      int'({r.hs, r.vs, r.hb, r.vb}));
                check("rgb_out",    int'(rgb_out), m_rgb(r, font));
            end
        end
    end

    task automatic step(input int h, input int v, input logic hb, input logic vb,
                        input logic [11:0] rgb);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = (h % 5) == 0;
        vsync_in  = (v % 3) == 0;
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
        @(negedge pclk);
    endtask

    task automatic idle2();
        step(0, 0, 1'b0, 1'b0, 12'h000);
        step(0, 0, 1'b0, 1'b0, 12'h000);
    endtask

    initial begin
        @(negedge pclk);
        // reset held with live inputs
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step(110 + i, 60 + i, 1'b0, 1'b0, 12'h5A5);
        check("rst_xy",   int'(char_xy), 0);
        check("rst_line", int'(char_line), 0);
        check("rst_rgb",  int'(rgb_out), 0);
        check("rst_h",    int'(hcount_out), 0);
        rst = 1'b0;

        // top-left corner
        font_ovr_en = 1'b1; font_ovr = 8'h80;
        step(100, 50, 1'b0, 1'b0, 12'h321);
        check("tl_xy", int'(char_xy), 8'h00);
        check("tl_line", int'(char_line), 0);
        idle2();
        check("tl_rgb", int'(rgb_out), int'(TEXT));

        // col 2 row 1 line 3, pixel 5 vs pixel 1
        font_ovr = 8'h04;
        step(121, 69, 1'b0, 1'b0, 12'h456);
        check("c12_xy", int'(char_xy), 8'h12);
        check("c12_line", int'(char_line), 3);
        idle2();
        check("c12_px5_rgb", int'(rgb_out), int'(TEXT));
        step(117, 69, 1'b0, 1'b0, 12'h456);
        check("c12b_xy", int'(char_xy), 8'h12);
        idle2();
        check("c12_px1_rgb", int'(rgb_out), 12'h456);

        // first pixel right of the box
        font_ovr = 8'hFF;
        step(228, 60, 1'b0, 1'b0, 12'h0F0);
        check("xout_xy", int'(char_xy), 0);
        idle2();
        check("xout_rgb", int'(rgb_out), 12'h0F0);

        // blanking beats font
        step(117, 69, 1'b1, 1'b0, 12'h777);
        idle2();
        check("blank_rgb", int'(rgb_out), 12'h000);
        check("blank_hblnk", int'(hblnk_out), 1);
        check("blank_hcount", int'(hcount_out), 117);
        check("blank_vcount", int'(vcount_out), 69);

        // zero font pixel: background or pass-through
        font_ovr = 8'h00;
        step(117, 69, 1'b0, 1'b0, 12'hABC);
        idle2();
`ifdef TEXT_BG_EN
        check("bg_rgb", int'(rgb_out), int'(BG));
`else
        check("bg_rgb", int'(rgb_out), 12'hABC);
`endif

        // edges of the rectangle
        step(227, 305, 1'b0, 1'b0, 12'h111);
        check("br_xy", int'(char_xy), 8'hFF);
        check("br_line", int'(char_line), 15);
        step(100, 306, 1'b0, 1'b0, 12'h111);
        check("yout_xy", int'(char_xy), 0);
        step(99, 50, 1'b0, 1'b0, 12'h111);
        check("xlo_xy", int'(char_xy), 0);
        step(100, 49, 1'b0, 1'b0, 12'h111);
        check("ylo_xy", int'(char_xy), 0);
        font_ovr_en = 1'b0;

        // raster sweep across all four edges with the hashed font
        for (int v = 46; v < 56; v++)
            for (int h = 92; h < 240; h++)
                step(h, v, h >= 236, 1'b0, 12'($urandom));
        for (int v = 300; v < 310; v++)
            for (int h = 92; h < 240; h++) begin
                if (v == 303 && h == 150) rst = 1'b1;
                if (v == 303 && h == 152) rst = 1'b0;
                step(h, v, 1'b0, v == 308, 12'($urandom));
            end
        for (int i = 0; i < 4; i++) step(0, 0, 1'b0, 1'b0, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
